// File: rtl/pipelined_subtractor.sv
// Two-stage signed subtractor: out = sat((a - b) >>> OUT_SCALE) with valid/ready
// handshakes on both sides, full backpressure and a saturation event counter.
module pipelined_subtractor #(
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 16,
  parameter int OUT_WIDTH = ((A_WIDTH > B_WIDTH) ? A_WIDTH : B_WIDTH) + 1,
  parameter int OUT_SCALE = 0,
  parameter int CNT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        arst_n_in,
  input  logic signed [A_WIDTH-1:0]   a_in,
  input  logic signed [B_WIDTH-1:0]   b_in,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic signed [OUT_WIDTH-1:0] out,
  output logic                        out_sat,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [CNT_WIDTH-1:0]        sat_count,
  input  logic                        sat_clr
);

  localparam int STAGES = 2;
  localparam int INT_W  = A_WIDTH + B_WIDTH;
  // Compare width covers both the internal difference and the output range.
  localparam int CW     = ((INT_W > OUT_WIDTH) ? INT_W : OUT_WIDTH) + 1;
  localparam logic signed [CW-1:0] MAXV = {{(CW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [CW-1:0] MINV = {{(CW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  typedef struct packed {
    logic signed [INT_W-1:0] a;
    logic signed [INT_W-1:0] b;
  } s1_t;

  s1_t                         s1_q;
  logic [STAGES:1]             vld_pipe;
  logic                        adv1, adv2;
  logic signed [INT_W-1:0]     diff, shifted;
  logic signed [CW-1:0]        shc;
  logic signed [OUT_WIDTH-1:0] res;
  logic                        sat;

  assign adv2      = !vld_pipe[2] | out_ready;
  assign adv1      = !vld_pipe[1] | adv2;
  assign in_ready  = adv1;
  assign out_valid = vld_pipe[2];

  assign diff    = s1_q.a - s1_q.b;
  assign shifted = diff >>> OUT_SCALE;
  assign shc     = CW'(shifted);

  always_comb begin
    res = shc[OUT_WIDTH-1:0];
    sat = 1'b0;
    if (shc > MAXV) begin
      res = MAXV[OUT_WIDTH-1:0];
      sat = 1'b1;
    end else if (shc < MINV) begin
      res = MINV[OUT_WIDTH-1:0];
      sat = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      out      <= '0;
      out_sat  <= 1'b0;
    end else begin
      if (adv1) vld_pipe[1] <= in_valid;
      if (in_valid && adv1) begin
        s1_q.a <= INT_W'(a_in);
        s1_q.b <= INT_W'(b_in);
      end
      if (adv2) begin
        vld_pipe[2] <= vld_pipe[1];
        out         <= res;
        out_sat     <= sat;
      end
    end
  end

  // Counts saturated results actually taken downstream; sticks at all-ones.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in)
      sat_count <= '0;
    else if (sat_clr)
      sat_count <= '0;
    else if (out_valid && out_ready && out_sat && !(&sat_count))
      sat_count <= sat_count + CNT_WIDTH'(1);
  end

endmodule

// File: tb/tb_pipelined_subtractor.sv
// Bench for pipelined_subtractor: three parameterisations share one stimulus
// stream and are checked every cycle against a transaction-level reference.
module tb_pipelined_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               arst_n_in;
  logic signed [15:0] a_in, b_in;
  logic               in_valid, out_ready, sat_clr;

  logic               in_ready1, in_ready2, in_ready3;
  logic               out_valid1, out_valid2, out_valid3;
  logic               out_sat1, out_sat2, out_sat3;
  logic signed [16:0] out1, out2;
  logic signed [7:0]  out3;
  logic [15:0]        cnt1, cnt2;
  logic [3:0]         cnt3;

  pipelined_subtractor u1 (
    .clk(clk), .arst_n_in(arst_n_in), .a_in(a_in), .b_in(b_in),
    .in_valid(in_valid), .in_ready(in_ready1), .out(out1), .out_sat(out_sat1),
    .out_valid(out_valid1), .out_ready(out_ready), .sat_count(cnt1), .sat_clr(sat_clr));

  pipelined_subtractor #(.OUT_SCALE(2)) u2 (
    .clk(clk), .arst_n_in(arst_n_in), .a_in(a_in), .b_in(b_in),
    .in_valid(in_valid), .in_ready(in_ready2), .out(out2), .out_sat(out_sat2),
    .out_valid(out_valid2), .out_ready(out_ready), .sat_count(cnt2), .sat_clr(sat_clr));

  pipelined_subtractor #(.OUT_WIDTH(8), .CNT_WIDTH(4)) u3 (
    .clk(clk), .arst_n_in(arst_n_in), .a_in(a_in), .b_in(b_in),
    .in_valid(in_valid), .in_ready(in_ready3), .out(out3), .out_sat(out_sat3),
    .out_valid(out_valid3), .out_ready(out_ready), .sat_count(cnt3), .sat_clr(sat_clr));

  localparam int     SC   [3] = '{0, 2, 0};
  localparam int     W    [3] = '{17, 17, 8};
  localparam longint CMAX [3] = '{65535, 65535, 15};

  typedef struct {
    longint a;
    longint b;
    int     cyc;
  } ent_t;

  ent_t        q[$];
  longint      mcnt [3];
  int          nchk, nfail, cyc;
  bit          prev_stall, acc_hs, saw_full;
  logic [63:0] prev_out [3];
  logic        prev_sat [3];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, $signed(obs), $signed(exp), cyc);
    end
  endtask

  // Reference: exact difference, floor shift, clamp to a w-bit signed range.
  function automatic void ref_sub(input longint a, input longint b, input int sc, input int w,
                                  output longint r, output bit s);
    longint d, mx, mn;
    d  = (a - b) >>> sc;
    mx = (longint'(1) << (w - 1)) - 1;
    mn = -mx - 1;
    r  = d;
    s  = 1'b0;
    if (d > mx) begin r = mx; s = 1'b1; end
    else if (d < mn) begin r = mn; s = 1'b1; end
  endfunction

  // One cycle: check everything at the falling edge, update the model, then
  // return just after the next rising edge so the caller can drive inputs.
  task automatic mon();
    logic [63:0] ov [3];
    logic [63:0] cv [3];
    logic        sv [3], vv [3], rv [3];
    bit          ev, er_rdy, es;
    longint      er;
    @(negedge clk);
    cyc++;
    ov[0] = {{47{out1[16]}}, out1}; ov[1] = {{47{out2[16]}}, out2}; ov[2] = {{56{out3[7]}}, out3};
    cv[0] = {48'b0, cnt1}; cv[1] = {48'b0, cnt2}; cv[2] = {60'b0, cnt3};
    sv[0] = out_sat1; sv[1] = out_sat2; sv[2] = out_sat3;
    vv[0] = out_valid1; vv[1] = out_valid2; vv[2] = out_valid3;
    rv[0] = in_ready1; rv[1] = in_ready2; rv[2] = in_ready3;
    ev     = (q.size() > 0) && (cyc - q[0].cyc >= 2);
    er_rdy = (q.size() < 2) || out_ready;
    for (int k = 0; k < 3; k++) begin
      chk("out_valid", vv[k], ev);
      chk("in_ready", rv[k], er_rdy);
      chk("sat_count", cv[k], mcnt[k]);
      if (prev_stall) begin
        chk("hold_out", ov[k], prev_out[k]);
        chk("hold_sat", sv[k], prev_sat[k]);
      end
      if (ev) begin
        ref_sub(q[0].a, q[0].b, SC[k], W[k], er, es);
        chk("out", ov[k], er);
        chk("out_sat", sv[k], es);
      end
    end
    if (ev && out_ready) begin
      for (int k = 0; k < 3; k++) begin
        ref_sub(q[0].a, q[0].b, SC[k], W[k], er, es);
        if (sat_clr) mcnt[k] = 0;
        else if (es && mcnt[k] < CMAX[k]) mcnt[k]++;
      end
      void'(q.pop_front());
    end else if (sat_clr) begin
      for (int k = 0; k < 3; k++) mcnt[k] = 0;
    end
    acc_hs = in_valid && er_rdy && arst_n_in;
    if (acc_hs) q.push_back('{longint'(a_in), longint'(b_in), cyc});
    if (!er_rdy) saw_full = 1'b1;
    prev_stall = ev && !out_ready;
    prev_out   = ov;
    prev_sat   = sv;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input longint a, input longint b);
    a_in = 16'(a); b_in = 16'(b); in_valid = 1'b1;
    mon();
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) mon();
  endtask

  initial begin
    int idx;
    nchk = 0; nfail = 0; cyc = 0;
    prev_stall = 1'b0; saw_full = 1'b0; acc_hs = 1'b0;
    for (int k = 0; k < 3; k++) begin mcnt[k] = 0; prev_out[k] = '0; prev_sat[k] = 1'b0; end
    arst_n_in = 1'b0; a_in = '0; b_in = '0; in_valid = 1'b0; out_ready = 1'b1; sat_clr = 1'b0;

    // Reset state
    #1;
    chk("rst_out_valid", out_valid1, 0);
    chk("rst_out", {{47{out1[16]}}, out1}, 0);
    chk("rst_out_sat", out_sat3, 0);
    chk("rst_sat_count", cnt1, 0);
    chk("rst_in_ready", in_ready1, 1);
    @(posedge clk); @(posedge clk); #1;
    arst_n_in = 1'b1;

    // Basic values, back-to-back at full throughput
    send(100, -50); send(-32768, 32767); send(7, 0); send(-7, 0);
    idle(3);
    sat_clr = 1'b1; mon(); sat_clr = 1'b0;
    send(200, 10); send(-200, 10);
    idle(3);
    chk("sat_count_two", cnt3, 2);

    // Clear colliding with a saturated output handshake
    send(200, 10);
    mon();
    sat_clr = 1'b1; mon(); sat_clr = 1'b0;
    mon();
    chk("clr_priority", cnt3, 0);

    // Counter pins at its maximum
    in_valid = 1'b1; a_in = 16'sd200; b_in = 16'sd10;
    for (int i = 0; i < 20; i++) mon();
    in_valid = 1'b0;
    idle(3);
    chk("cnt_pinned", cnt3, 15);
    send(-200, 10);
    idle(3);
    chk("cnt_still_pinned", cnt3, 15);

    // Asynchronous reset with both stages full
    out_ready = 1'b0;
    in_valid = 1'b1; a_in = 16'sd300; b_in = -16'sd5;
    mon(); mon(); mon();
    in_valid = 1'b0;
    chk("both_full_stall", in_ready1, 0);
    arst_n_in = 1'b0;
    #1;
    chk("arst_out_valid", out_valid1, 0);
    chk("arst_out_valid3", out_valid3, 0);
    chk("arst_sat_count3", cnt3, 0);
    chk("arst_out3", {{56{out3[7]}}, out3}, 0);
    q.delete();
    for (int k = 0; k < 3; k++) mcnt[k] = 0;
    prev_stall = 1'b0;
    mon(); mon();
    arst_n_in = 1'b1;
    out_ready = 1'b1;
    idle(3);
    send(100, -50);
    idle(3);

    // Backpressure: five back-to-back operands, out_ready low on cycles 3..6
    saw_full = 1'b0;
    idx = 0;
    for (int i = 0; i < 40 && (idx < 5 || q.size() > 0); i++) begin
      in_valid  = (idx < 5);
      a_in      = 16'(1000 * (idx + 1) - 7 * idx);
      b_in      = 16'(-333 * idx);
      out_ready = !(i >= 3 && i <= 6);
      mon();
      if (acc_hs) idx++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_all_sent", idx, 5);
    chk("bp_drained", q.size(), 0);
    chk("bp_in_ready_dropped", saw_full, 1);

    // Random traffic with random stalls and clears
    for (int i = 0; i < 400; i++) begin
      a_in      = ($urandom_range(0, 7) == 0) ? 16'sh8000 : 16'($urandom);
      b_in      = ($urandom_range(0, 7) == 0) ? 16'sh7fff : 16'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      sat_clr   = ($urandom_range(0, 31) == 0);
      mon();
    end
    in_valid = 1'b0; out_ready = 1'b1; sat_clr = 1'b0;
    idle(4);
    chk("rand_drained", q.size(), 0);

    $display("%0d/%0d checks passed", nchk - nfail, nchk);
    $finish;
  end

endmodule

// File: doc/pipelined_subtractor.md
Name: pipelined_subtractor

Overview:
- Signed two-operand subtractor computing out = (a − b) >>> OUT_SCALE, with saturation to OUT_WIDTH.
- Provides the negating counterpart of the datapath adder, for residual/difference computation (e.g. accumulator drain, bias removal) in the accelerator datapath.
- Two-stage register pipeline with valid/ready handshakes on both sides, full backpressure support, and a saturation event counter for debug.

Parameters:
- A_WIDTH, 16, width of signed minuend a_in
- B_WIDTH, 16, width of signed subtrahend b_in
- OUT_WIDTH, max(A_WIDTH,B_WIDTH)+1, width of signed result
- OUT_SCALE, 0, arithmetic right-shift applied to the exact difference
- CNT_WIDTH, 16, width of saturation event counter

Ports:
- clk  input  1  clock, all state on rising edge
- arst_n_in  input  1  asynchronous active-low reset
- a_in  input  A_WIDTH  signed minuend
- b_in  input  B_WIDTH  signed subtrahend
- in_valid  input  1  operands valid
- in_ready  output  1  pipeline accepts operands this cycle
- out  output  OUT_WIDTH  signed scaled/saturated difference
- out_sat  output  1  out was clamped (qualified by out_valid)
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- sat_count  output  CNT_WIDTH  number of saturated results accepted downstream
- sat_clr  input  1  synchronous clear of sat_count

Behaviour:
- Reset (async assert, sync-safe deassert):
  - s1_valid = s2_valid = out_valid = 0
  - out = 0, out_sat = 0, sat_count = 0
  - all stage data registers = 0
  - reset mid-operation discards in-flight data; no output pulse follows.
- Handshake and pipeline control:
  - A transfer occurs when valid & ready are both high on a rising edge.
  - adv2 = !s2_valid | out_ready; adv1 = !s1_valid | adv2; in_ready = adv1 (combinational, no bubble at full throughput).
  - Stage 1 loads on in_valid & in_ready.
  - Stage 2 loads on adv2; s2_valid <= s1_valid when adv2.
  - s1_valid <= in_valid when adv1.
- Stage 1 registers a_in, b_in sign-extended to INT_W = A_WIDTH+B_WIDTH.
- Stage 2 datapath:
  - diff = a_ext − b_ext, exact in INT_W; no overflow possible.
  - shifted = diff >>> OUT_SCALE, floor rounding, matching the adder's scaling.
  - If shifted > 2^(OUT_WIDTH−1)−1: out = max positive, sat = 1.
  - If shifted < −2^(OUT_WIDTH−1): out = min negative, sat = 1.
  - Otherwise out = shifted[OUT_WIDTH−1:0], sat = 0.
- Latency and throughput:
  - Latency 2 cycles from input handshake to out_valid with no stall; throughput 1 result/cycle.
  - While out_valid & !out_ready, out and out_sat hold stable; stage 1 holds if occupied; in_ready = 0 when both stages are full.
- sat_count:
  - Increments on out_valid & out_ready & out_sat.
  - Saturates at 2^CNT_WIDTH−1; no wrap.
  - sat_clr has priority over a same-cycle increment; result is 0.
- Simultaneous input accept and output drain on the same edge is legal and loses no data.

Test Plan:
- Defaults, out_ready=1: a=100, b=−50 -> out=150 two cycles after handshake, out_sat=0; a=−32768, b=32767 -> out=−65535 (17-bit), no saturation.
- OUT_SCALE=2: a=7, b=0 -> out=1; a=−7, b=0 -> out=−2 (floor).
- OUT_WIDTH=8: a=200, b=10 -> out=127, out_sat=1; a=−200, b=10 -> out=−128, out_sat=1; sat_count = 2 after both accepted.
- Backpressure: stream 5 back-to-back operands, out_ready low cycles 3–6 -> in_ready drops once both stages are full, out stable while stalled, all 5 results delivered in order with no duplicates or losses.
- sat_clr asserted in the same cycle as a saturated output handshake -> sat_count = 0 next cycle; sat_count pinned at 0xFFFF (preloaded via 65535+ saturated results, or forced) stays 0xFFFF on the next saturation.
- Assert arst_n_in low while both stages hold data -> out_valid = 0 and sat_count = 0 immediately (asynchronous); after release no stale result appears, and the next operand pair yields the correct result at latency 2.
